// File: rtl/ovf_handshake_ctrl.sv
// ovf_handshake_ctrl
//
// Overflow-handshake controller. A rising edge on start arms a beat counter
// with a clamped threshold taken from cfg_thresh. When the number of accepted
// beats reaches that threshold, o_ovf ("room available") drops and stays low
// until downstream acknowledges with a rising edge on i_ovf. The controller
// then re-arms, or goes idle if start is no longer high.
//
// Ports:
//   clk          in   1      clock, all state updates on posedge
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      enable, rising edge arms counting
//   in_valid     in   1      one data beat per cycle when high
//   cfg_thresh   in   CNT_W  beat threshold, sampled on start rise / re-arm
//   i_ovf        in   1      downstream acknowledge, rising edge only
//   o_ovf        out  1      room available, low while awaiting acknowledge
//   busy         out  1      high in COUNT or OVF
//   ovf_evt_cnt  out  EVT_W  saturating count of overflow events
//   ack_err      out  1      one-cycle pulse after an i_ovf rise outside OVF

module ovf_handshake_ctrl #(
  parameter int CNT_W   = 5,
  parameter int THR_MIN = 1,
  parameter int THR_MAX = 19,
  parameter int EVT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             i_ovf,
  output logic             o_ovf,
  output logic             busy,
  output logic [EVT_W-1:0] ovf_evt_cnt,
  output logic             ack_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_OVF   = 2'd2;

  localparam logic [CNT_W-1:0] THR_MIN_C = CNT_W'(THR_MIN);
  localparam logic [CNT_W-1:0] THR_MAX_C = CNT_W'(THR_MAX);

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] thr, thr_d;
  logic             o_ovf_q, o_ovf_d;
  logic             start_q;
  logic             i_ovf_q;
  logic             evt_inc;

  logic             start_rise;
  logic             ack_rise;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] thr_clamped;
  logic             thr_hit;

  function automatic logic [CNT_W-1:0] clamp_thr(input logic [CNT_W-1:0] t);
    if (t < THR_MIN_C)      return THR_MIN_C;
    else if (t > THR_MAX_C) return THR_MAX_C;
    else                    return t;
  endfunction

  assign start_rise  = start & ~start_q;
  assign ack_rise    = i_ovf & ~i_ovf_q;
  assign cnt_inc     = cnt + {{(CNT_W-1){1'b0}}, in_valid};
  assign thr_clamped = clamp_thr(cfg_thresh);
  // The count including this edge's beat is compared, so the threshold is
  // detected on the edge that accepts the final beat rather than one later.
  assign thr_hit     = (cnt_inc == thr);

  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a
    // path through the case that skips an assignment would infer a latch.
    state_d = state;
    cnt_d   = cnt;
    thr_d   = thr;
    o_ovf_d = o_ovf_q;
    evt_inc = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_d   = '0;
        o_ovf_d = 1'b1;
        if (start_rise) begin
          thr_d   = thr_clamped;
          state_d = S_COUNT;
        end
      end

      S_COUNT: begin
        o_ovf_d = 1'b1;
        // Reaching the threshold wins over start falling on the same edge.
        if (thr_hit) begin
          state_d = S_OVF;
          cnt_d   = cnt_inc;
          o_ovf_d = 1'b0;
          evt_inc = 1'b1;
        end else if (!start) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_OVF: begin
        // Beats and start edges are ignored; only an acknowledge leaves OVF.
        o_ovf_d = 1'b0;
        if (ack_rise) begin
          o_ovf_d = 1'b1;
          cnt_d   = '0;
          if (start) begin
            state_d = S_COUNT;
            thr_d   = thr_clamped;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        o_ovf_d = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      thr         <= '0;
      o_ovf_q     <= 1'b1;
      start_q     <= 1'b0;
      i_ovf_q     <= 1'b0;
      ovf_evt_cnt <= '0;
      ack_err     <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      thr     <= thr_d;
      o_ovf_q <= o_ovf_d;
      start_q <= start;
      i_ovf_q <= i_ovf;
      if (evt_inc && (ovf_evt_cnt != '1)) begin
        ovf_evt_cnt <= ovf_evt_cnt + 1'b1;
      end
      ack_err <= ack_rise & (state != S_OVF);
    end
  end

  // The acknowledge term lets o_ovf rise in the same cycle that i_ovf rises;
  // o_ovf_q catches up on the following edge.
  assign o_ovf = o_ovf_q | ((state == S_OVF) & ack_rise);
  assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_ovf_handshake_ctrl.sv
// tb_ovf_handshake_ctrl
//
// Bench for ovf_handshake_ctrl: a table of directed vectors for the basic
// handshake, re-arm, clamping and simultaneous-event cases, followed by
// hand-written sequences for the longer multi-cycle corner cases.

module tb_ovf_handshake_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [4:0] cfg_thresh;
  logic       i_ovf;
  logic       o_ovf;
  logic       busy;
  logic [7:0] ovf_evt_cnt;
  logic       ack_err;

  int n_checks = 0;
  int n_bad    = 0;
  int exp_evt  = 0;

  ovf_handshake_ctrl #(
    .CNT_W  (5),
    .THR_MIN(1),
    .THR_MAX(19),
    .EVT_W  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .cfg_thresh (cfg_thresh),
    .i_ovf      (i_ovf),
    .o_ovf      (o_ovf),
    .busy       (busy),
    .ovf_evt_cnt(ovf_evt_cnt),
    .ack_err    (ack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       in_valid;
    logic [4:0] cfg;
    logic       i_ovf;
    logic       pre_o;   // o_ovf just after driving inputs, before the edge
    logic       o;       // outputs after the edge
    logic       busy;
    logic [7:0] evt;
    logic       err;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(input logic s, iv, input logic [4:0] c,
                              input logic io, po, o, b,
                              input logic [7:0] e, input logic r);
    vec_t v;
    v.start = s; v.in_valid = iv; v.cfg = c; v.i_ovf = io;
    v.pre_o = po; v.o = o; v.busy = b; v.evt = e; v.err = r;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From IDLE with i_ovf low: raise start with in_valid held high, find the
  // edge after which o_ovf is low, then acknowledge with start low.
  task automatic run_to_ovf(input logic [4:0] cfg, input int thr, input string tag);
    int k;
    start = 1'b1; in_valid = 1'b1; cfg_thresh = cfg;
    tick();
    check({tag, "_arm_busy"}, busy, 1);
    check({tag, "_arm_o"}, o_ovf, 1);
    k = 1;
    while (k <= 40) begin
      tick();
      if (o_ovf == 1'b0) break;
      k++;
    end
    check({tag, "_fall_edge"}, k, thr);
    exp_evt++;
    check({tag, "_evt"}, ovf_evt_cnt, exp_evt);
    i_ovf = 1'b1; start = 1'b0;
    #1;
    check({tag, "_ack_o_same_cycle"}, o_ovf, 1);
    tick();
    check({tag, "_ack_busy"}, busy, 0);
    i_ovf = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; cfg_thresh = 5'd5; i_ovf = 1'b0;

    // Base handshake with thr=5, re-arm with i_ovf held high, idle ack_err.
    tbl[0]  = mk(0,0,5,0, 1,1,0,0,0);
    tbl[1]  = mk(1,1,5,0, 1,1,1,0,0);
    tbl[2]  = mk(1,1,5,0, 1,1,1,0,0);
    tbl[3]  = mk(1,1,5,0, 1,1,1,0,0);
    tbl[4]  = mk(1,1,5,0, 1,1,1,0,0);
    tbl[5]  = mk(1,1,5,0, 1,1,1,0,0);
    tbl[6]  = mk(1,1,5,0, 1,0,1,1,0);
    tbl[7]  = mk(1,1,5,0, 0,0,1,1,0);
    tbl[8]  = mk(1,1,5,0, 0,0,1,1,0);
    tbl[9]  = mk(1,1,5,1, 1,1,1,1,0);
    tbl[10] = mk(1,1,5,1, 1,1,1,1,0);
    tbl[11] = mk(1,1,5,1, 1,1,1,1,0);
    tbl[12] = mk(1,1,5,1, 1,1,1,1,0);
    tbl[13] = mk(1,1,5,1, 1,1,1,1,0);
    tbl[14] = mk(1,1,5,1, 1,0,1,2,0);
    tbl[15] = mk(1,1,5,1, 0,0,1,2,0);
    tbl[16] = mk(1,1,5,0, 0,0,1,2,0);
    tbl[17] = mk(0,1,5,1, 1,1,0,2,0);
    tbl[18] = mk(0,0,5,0, 1,1,0,2,0);
    tbl[19] = mk(0,0,5,1, 1,1,0,2,1);
    tbl[20] = mk(0,0,5,1, 1,1,0,2,0);
    tbl[21] = mk(0,0,5,0, 1,1,0,2,0);
    // cfg_thresh=0 clamps to 1; start fall and start rise in OVF are ignored.
    tbl[22] = mk(1,1,0,0, 1,1,1,2,0);
    tbl[23] = mk(1,1,0,0, 1,0,1,3,0);
    tbl[24] = mk(0,1,0,0, 0,0,1,3,0);
    tbl[25] = mk(1,1,0,0, 0,0,1,3,0);
    tbl[26] = mk(0,0,0,1, 1,1,0,3,0);
    tbl[27] = mk(0,0,0,0, 1,1,0,3,0);

    tick();
    tick();
    check("rst_o", o_ovf, 1);
    check("rst_busy", busy, 0);
    check("rst_evt", ovf_evt_cnt, 0);
    check("rst_err", ack_err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      start = tbl[i].start; in_valid = tbl[i].in_valid;
      cfg_thresh = tbl[i].cfg; i_ovf = tbl[i].i_ovf;
      #1;
      check($sformatf("v%0d_pre_o", i), o_ovf, tbl[i].pre_o);
      tick();
      check($sformatf("v%0d_o", i), o_ovf, tbl[i].o);
      check($sformatf("v%0d_busy", i), busy, tbl[i].busy);
      check($sformatf("v%0d_evt", i), ovf_evt_cnt, tbl[i].evt);
      check($sformatf("v%0d_err", i), ack_err, tbl[i].err);
    end
    exp_evt = 3;

    // cfg_thresh=31 clamps to 19: o_ovf first low after edge 19.
    run_to_ovf(5'd31, 19, "clamp_hi");

    // thr=3 with in_valid alternating 1,0,1,0,...: third beat lands on edge 5.
    start = 1'b1; cfg_thresh = 5'd3; in_valid = 1'b0;
    tick();
    for (int k = 1; k <= 6; k++) begin
      in_valid = k[0];
      tick();
      check($sformatf("toggle_e%0d_o", k), o_ovf, (k < 5) ? 1 : 0);
    end
    exp_evt++;
    check("toggle_evt", ovf_evt_cnt, exp_evt);
    i_ovf = 1'b1; start = 1'b0;
    tick();
    i_ovf = 1'b0;
    tick();
    check("toggle_exit_busy", busy, 0);

    // start dropped at count=2 with thr=5: back to IDLE, no event.
    start = 1'b1; cfg_thresh = 5'd5; in_valid = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0;
    tick();
    check("drop_busy", busy, 0);
    check("drop_o", o_ovf, 1);
    check("drop_evt", ovf_evt_cnt, exp_evt);

    // i_ovf pulse while counting: one-cycle ack_err, no state change.
    start = 1'b1; cfg_thresh = 5'd10; in_valid = 1'b1;
    tick();
    tick();
    i_ovf = 1'b1;
    #1;
    check("cnt_ack_pre_o", o_ovf, 1);
    tick();
    check("cnt_ack_err", ack_err, 1);
    check("cnt_ack_o", o_ovf, 1);
    check("cnt_ack_busy", busy, 1);
    i_ovf = 1'b0;
    tick();
    check("cnt_ack_err_clear", ack_err, 0);
    check("cnt_ack_still_busy", busy, 1);
    start = 1'b0;
    tick();
    check("cnt_ack_idle", busy, 0);
    check("cnt_ack_evt", ovf_evt_cnt, exp_evt);

    // Asynchronous reset while in OVF takes effect between edges.
    start = 1'b1; cfg_thresh = 5'd2; in_valid = 1'b1;
    tick();
    tick();
    tick();
    check("areset_in_ovf", o_ovf, 0);
    #2;
    rst_n = 1'b0; start = 1'b0;
    #1;
    check("areset_o", o_ovf, 1);
    check("areset_busy", busy, 0);
    check("areset_evt", ovf_evt_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_evt = 0;
    run_to_ovf(5'd5, 5, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_bad);
    $finish;
  end

endmodule
